// File: rtl/fifo_collect_pkg.sv
// Shared types and defaults for the result collector and its round-robin picker.
package fifo_collect_pkg;

   localparam int unsigned DEF_NUM_BLOCKS  = 12;
   localparam int unsigned DEF_RESULT_BITS = 64;
   localparam int unsigned REQ_LATENCY     = 2;
   localparam int unsigned SETTLE_CYCLES   = 4;
   localparam int unsigned IDX_W           = 4;

   typedef logic [IDX_W-1:0] blk_idx_t;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      DRAIN,
      HOLD,
      SETTLE
   } state_t;

endpackage : fifo_collect_pkg

// File: rtl/fifo_collect_rr_pick.sv
// Combinational round-robin search: first non-empty block after ptr_i, wrapping N->1.
module rr_pick
   import fifo_collect_pkg::*;
#(
   parameter int unsigned N = DEF_NUM_BLOCKS
) (
   input  logic [1:N] empty_i,
   input  blk_idx_t   ptr_i,
   output logic       hit_c,
   output blk_idx_t   idx_c
);

   blk_idx_t cand;

   // Scan ptr+1, ptr+2, ... and keep the first block holding a complete result
   always_comb begin
      hit_c = 1'b0;
      idx_c = ptr_i;
      cand  = '0;
      for (int unsigned k = 1; k <= N; k++) begin
         cand = blk_idx_t'((32'(ptr_i) + k - 1) % N + 1);
         if (!hit_c && !empty_i[cand]) begin
            hit_c = 1'b1;
            idx_c = cand;
         end
      end
   end

endmodule : rr_pick

// File: rtl/fifo_collect.sv
// Collects serial result bursts from the block FIFOs and presents them as parallel words.
module fifo_collect
   import fifo_collect_pkg::*;
#(
   parameter int unsigned NUM_BLOCKS  = DEF_NUM_BLOCKS,
   parameter int unsigned RESULT_BITS = DEF_RESULT_BITS
) (
   input  logic                   fifo_clk,
   input  logic                   fifo_rst_n,
   input  logic [1:NUM_BLOCKS]    fifo_empty,
   output logic [1:NUM_BLOCKS]    fifo_req,
   input  logic                   fifo_bit,
   output logic                   res_valid,
   input  logic                   res_ready,
   output logic [RESULT_BITS-1:0] res_data,
   output logic [3:0]             res_src,
   output logic                   err_underrun
);

   localparam int unsigned CNT_W = $clog2(RESULT_BITS + 1);
   localparam int unsigned SET_W = $clog2(SETTLE_CYCLES + 1);

   state_t                   state_q, state_d;
   blk_idx_t                 ptr_q, ptr_d;
   blk_idx_t                 sel_q, sel_d;
   logic [1:NUM_BLOCKS]      req_q, req_d;
   logic [CNT_W-1:0]         req_cnt_q, req_cnt_d;
   logic [CNT_W-1:0]         cap_cnt_q, cap_cnt_d;
   logic [REQ_LATENCY-1:0]   vld_q, vld_d;
   logic [RESULT_BITS-1:0]   shift_q, shift_d;
   logic [SET_W-1:0]         settle_q, settle_d;
   logic                     res_valid_q, res_valid_d;
   logic [RESULT_BITS-1:0]   res_data_q, res_data_d;
   blk_idx_t                 res_src_q, res_src_d;
   logic                     err_q, err_d;

   logic                     hit_c;
   blk_idx_t                 pick_c;
   logic                     done_c;
   logic                     out_free_c;

   rr_pick #(
      .N (NUM_BLOCKS)
   ) u_pick (
      .empty_i (fifo_empty),
      .ptr_i   (ptr_q),
      .hit_c   (hit_c),
      .idx_c   (pick_c)
   );

   // Capture path: delayed req strobes shift fifo_bit in, MSB first
   always_comb begin
      vld_d     = {vld_q[REQ_LATENCY-2:0], |req_q};
      shift_d   = shift_q;
      cap_cnt_d = cap_cnt_q;
      if (state_q == IDLE) begin
         cap_cnt_d = '0;
      end else if (vld_q[REQ_LATENCY-1]) begin
         shift_d   = {shift_q[RESULT_BITS-2:0], fifo_bit};
         cap_cnt_d = cap_cnt_q + CNT_W'(1);
      end
      done_c = (cap_cnt_d == CNT_W'(RESULT_BITS));
   end

   // Control FSM: pick a block, burst its pops, hand off the word, let empty flags settle
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      sel_d       = sel_q;
      req_d       = '0;
      req_cnt_d   = req_cnt_q;
      settle_d    = settle_q;
      res_valid_d = res_valid_q & ~res_ready;
      res_data_d  = res_data_q;
      res_src_d   = res_src_q;
      err_d       = err_q;
      out_free_c  = !res_valid_q || res_ready;

      case (state_q)
         IDLE: begin
            if (hit_c) begin
               sel_d         = pick_c;
               ptr_d         = pick_c;
               req_d[pick_c] = 1'b1;
               req_cnt_d     = '0;
               state_d       = REQ;
            end
         end
         REQ: begin
            if (fifo_empty[sel_q]) begin
               err_d = 1'b1;
            end
            if (req_cnt_q == CNT_W'(RESULT_BITS - 1)) begin
               state_d = DRAIN;
            end else begin
               req_d[sel_q] = 1'b1;
               req_cnt_d    = req_cnt_q + CNT_W'(1);
            end
         end
         DRAIN: begin
            if (done_c) begin
               if (out_free_c) begin
                  res_valid_d = 1'b1;
                  res_data_d  = shift_d;
                  res_src_d   = sel_q;
                  settle_d    = '0;
                  state_d     = SETTLE;
               end else begin
                  state_d = HOLD;
               end
            end
         end
         HOLD: begin
            if (out_free_c) begin
               res_valid_d = 1'b1;
               res_data_d  = shift_q;
               res_src_d   = sel_q;
               settle_d    = '0;
               state_d     = SETTLE;
            end
         end
         SETTLE: begin
            if (settle_q == SET_W'(SETTLE_CYCLES - 1)) begin
               state_d = IDLE;
            end else begin
               settle_d = settle_q + SET_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge fifo_clk) begin
      if (!fifo_rst_n) begin
         state_q     <= IDLE;
         ptr_q       <= blk_idx_t'(NUM_BLOCKS);
         sel_q       <= '0;
         req_q       <= '0;
         req_cnt_q   <= '0;
         cap_cnt_q   <= '0;
         vld_q       <= '0;
         shift_q     <= '0;
         settle_q    <= '0;
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
         res_src_q   <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         sel_q       <= sel_d;
         req_q       <= req_d;
         req_cnt_q   <= req_cnt_d;
         cap_cnt_q   <= cap_cnt_d;
         vld_q       <= vld_d;
         shift_q     <= shift_d;
         settle_q    <= settle_d;
         res_valid_q <= res_valid_d;
         res_data_q  <= res_data_d;
         res_src_q   <= res_src_d;
         err_q       <= err_d;
      end
   end

   assign fifo_req     = req_q;
   assign res_valid    = res_valid_q;
   assign res_data     = res_data_q;
   assign res_src      = res_src_q;
   assign err_underrun = err_q;

endmodule : fifo_collect

// File: tb/tb_fifo_collect.sv
// Bench for fifo_collect: block FIFO model, scoreboard of expected words, directed scenarios.
module tb_fifo_collect;

   localparam int unsigned NB = 12;
   localparam int unsigned RB = 64;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [1:NB]   fifo_empty;
   logic [1:NB]   fifo_req;
   logic [1:NB]   force_empty;
   logic          fifo_bit;
   logic          res_valid;
   logic          res_ready;
   logic [RB-1:0] res_data;
   logic [3:0]    res_src;
   logic          err_underrun;

   typedef struct {
      logic [3:0]  src;
      logic [63:0] data;
      bit          chk_data;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_errors = 0;

   logic [63:0] mem [1:NB][0:7];
   int          wr_cnt [1:NB];
   int          rd_cnt [1:NB];
   int          bitpos [1:NB];
   logic        blk_q;

   logic        prev_hold;
   logic [63:0] prev_data;
   logic [3:0]  prev_src;

   fifo_collect dut (
      .fifo_clk     (clk),
      .fifo_rst_n   (rst_n),
      .fifo_empty   (fifo_empty),
      .fifo_req     (fifo_req),
      .fifo_bit     (fifo_bit),
      .res_valid    (res_valid),
      .res_ready    (res_ready),
      .res_data     (res_data),
      .res_src      (res_src),
      .err_underrun (err_underrun)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic load(input int b, input logic [63:0] d);
      mem[4'(b)][3'(wr_cnt[4'(b)])] = d;
      wr_cnt[4'(b)] = wr_cnt[4'(b)] + 1;
   endtask

   task automatic expect_word(input int b, input logic [63:0] d, input bit cd);
      exp_t e;
      e.src      = 4'(b);
      e.data     = d;
      e.chk_data = cd;
      sb.push_back(e);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step(3);
      sb.delete();
      rst_n = 1'b1;
      step(1);
   endtask

   task automatic wait_sb(input string tag, input int bound);
      int n;
      n = 0;
      while (sb.size() != 0 && n < bound) begin
         step(1);
         n++;
      end
      chk(tag, 64'(sb.size()), 64'(0));
   endtask

   // Block empty flags: no complete result left, or forced high for the underrun case
   always_comb begin
      for (int b = 1; b <= NB; b++) begin
         fifo_empty[4'(b)] = (wr_cnt[4'(b)] == rd_cnt[4'(b)]) || force_empty[4'(b)];
      end
   end

   // Block FIFO model: one register in the block, one in the OR tree, MSB popped first
   always @(posedge clk) begin
      logic        ob;
      logic [63:0] w;
      ob = 1'b0;
      w  = '0;
      if (!rst_n) begin
         for (int b = 1; b <= NB; b++) bitpos[4'(b)] <= 0;
         blk_q    <= 1'b0;
         fifo_bit <= 1'b0;
      end else begin
         for (int b = 1; b <= NB; b++) begin
            if (fifo_req[4'(b)] && wr_cnt[4'(b)] != rd_cnt[4'(b)]) begin
               w  = mem[4'(b)][3'(rd_cnt[4'(b)])];
               ob = ob | w[6'(63 - bitpos[4'(b)])];
               if (bitpos[4'(b)] == 63) begin
                  bitpos[4'(b)] <= 0;
                  rd_cnt[4'(b)] <= rd_cnt[4'(b)] + 1;
               end else begin
                  bitpos[4'(b)] <= bitpos[4'(b)] + 1;
               end
            end
         end
         blk_q    <= ob;
         fifo_bit <= blk_q;
      end
   end

   // Output monitor: one-hot requests, stability under back-pressure, scoreboard on transfer
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         prev_hold <= 1'b0;
      end else begin
         chk("req_onehot", 64'($onehot0(fifo_req)), 64'(1));
         if (prev_hold) begin
            chk("hold_data", res_data, prev_data);
            chk("hold_src", 64'(res_src), 64'(prev_src));
         end
         if (res_valid && res_ready) begin
            if (sb.size() == 0) begin
               chk("unexpected_src", 64'(res_src), 64'(0));
            end else begin
               e = sb.pop_front();
               chk("res_src", 64'(res_src), 64'(e.src));
               if (e.chk_data) chk("res_data", res_data, e.data);
            end
         end
         prev_hold <= res_valid && !res_ready;
         prev_data <= res_data;
         prev_src  <= res_src;
      end
   end

   initial begin
      int n;
      int nreq;
      int nval;
      rst_n       = 1'b0;
      res_ready   = 1'b1;
      force_empty = '0;
      step(1);
      do_reset();

      // Reset values
      chk("rst_req", 64'(fifo_req), 64'(0));
      chk("rst_valid", 64'(res_valid), 64'(0));
      chk("rst_data", res_data, 64'(0));
      chk("rst_src", 64'(res_src), 64'(0));
      chk("rst_err", 64'(err_underrun), 64'(0));

      // Single block 5: burst length and latency
      load(5, 64'hDEADBEEF_01234567);
      expect_word(5, 64'hDEADBEEF_01234567, 1'b1);
      n = 0;
      while (fifo_req == '0 && n < 20) begin
         step(1);
         n++;
      end
      chk("t1_req5", 64'(fifo_req[5]), 64'(1));
      n = 0;
      while (fifo_req[5] && n < 100) begin
         step(1);
         n++;
      end
      chk("t1_req_len", 64'(n), 64'(64));
      n = 65;
      while (!res_valid && n < 100) begin
         step(1);
         n++;
      end
      chk("t1_valid_cycle", 64'(n), 64'(67));
      chk("t1_data", res_data, 64'hDEADBEEF_01234567);
      step(1);
      chk("t1_valid_fall", 64'(res_valid), 64'(0));
      wait_sb("t1_sb", 50);

      // Round robin over blocks 3, 7, 12
      do_reset();
      load(3, 64'h3333_0000_AAAA_0001);
      load(3, 64'h3333_0000_AAAA_0002);
      load(7, 64'h7777_1234_5678_9ABC);
      load(12, 64'hC0C0_FFFF_0000_1212);
      expect_word(3, 64'h3333_0000_AAAA_0001, 1'b1);
      expect_word(7, 64'h7777_1234_5678_9ABC, 1'b1);
      expect_word(12, 64'hC0C0_FFFF_0000_1212, 1'b1);
      expect_word(3, 64'h3333_0000_AAAA_0002, 1'b1);
      wait_sb("t2_sb", 400);

      // Back-pressure: first word held, second waits, then both drain back-to-back
      do_reset();
      res_ready = 1'b0;
      load(2, 64'hA5A5_5A5A_0F0F_F0F0);
      load(4, 64'h0123_4567_89AB_CDEF);
      expect_word(2, 64'hA5A5_5A5A_0F0F_F0F0, 1'b1);
      expect_word(4, 64'h0123_4567_89AB_CDEF, 1'b1);
      step(200);
      chk("t3_hold_valid", 64'(res_valid), 64'(1));
      chk("t3_hold_src", 64'(res_src), 64'(2));
      chk("t3_hold_data", res_data, 64'hA5A5_5A5A_0F0F_F0F0);
      chk("t3_no_req", 64'(fifo_req), 64'(0));
      res_ready = 1'b1;
      step(1);
      chk("t3_b2b_valid", 64'(res_valid), 64'(1));
      chk("t3_b2b_src", 64'(res_src), 64'(4));
      wait_sb("t3_sb", 20);

      // Underrun on block 9 at req cycle 20
      do_reset();
      load(9, 64'h9999_8888_7777_6666);
      expect_word(9, 64'h0, 1'b0);
      n = 0;
      while (!fifo_req[9] && n < 20) begin
         step(1);
         n++;
      end
      chk("t4_req9", 64'(fifo_req[9]), 64'(1));
      step(19);
      chk("t4_err_before", 64'(err_underrun), 64'(0));
      force_empty[9] = 1'b1;
      step(1);
      chk("t4_err_set", 64'(err_underrun), 64'(1));
      wait_sb("t4_sb", 200);
      force_empty[9] = 1'b0;
      step(50);
      chk("t4_err_sticky", 64'(err_underrun), 64'(1));

      // Reset mid-burst on block 4, then block 1 wins first
      do_reset();
      chk("t5_err_clr", 64'(err_underrun), 64'(0));
      load(4, 64'h4444_DEAD_4444_BEEF);
      n = 0;
      while (!fifo_req[4] && n < 20) begin
         step(1);
         n++;
      end
      chk("t5_req4", 64'(fifo_req[4]), 64'(1));
      step(29);
      load(1, 64'h1111_2222_3333_4444);
      load(8, 64'h8080_8080_0808_0808);
      rst_n = 1'b0;
      step(1);
      chk("t5_rst_req", 64'(fifo_req), 64'(0));
      chk("t5_rst_valid", 64'(res_valid), 64'(0));
      step(2);
      sb.delete();
      expect_word(1, 64'h1111_2222_3333_4444, 1'b1);
      expect_word(4, 64'h4444_DEAD_4444_BEEF, 1'b1);
      expect_word(8, 64'h8080_8080_0808_0808, 1'b1);
      rst_n = 1'b1;
      n = 0;
      while (fifo_req == '0 && n < 20) begin
         step(1);
         n++;
      end
      chk("t5_first_req1", 64'(fifo_req[1]), 64'(1));
      wait_sb("t5_sb", 400);

      // All empty: nothing happens
      do_reset();
      nreq = 0;
      nval = 0;
      for (int i = 0; i < 1000; i++) begin
         if (fifo_req != '0) nreq++;
         if (res_valid) nval++;
         step(1);
      end
      chk("t6_no_req", 64'(nreq), 64'(0));
      chk("t6_no_valid", 64'(nval), 64'(0));

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule : tb_fifo_collect
